ex_mem_reg: RTL and testbench

EX/MEM pipeline register of the 64-bit pipelined ARM CPU. It captures execute-stage results and control each cycle and presents them to the memory stage under the memory-stage port names. It supports stall (hold) and flush (bubble insertion). It also produces forwarding-hit flags so the execute stage can bypass results held in the memory stage.

---
 rtl/ex_mem_reg.sv | 99 +++++++++
 tb/tb_ex_mem_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, forwarding-hit flags and optional perf counters.
// Define EX_MEM_PERF_CNT_EN to build the saturating bubble/stall counters; otherwise they read 0.
module ex_mem_reg #(
   parameter int DW = 64,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall_in,
   input  logic          flush_in,
   input  logic          ex_valid,
   input  logic          ex_MemWrite,
   input  logic          ex_read_en,
   input  logic          ex_RegWrite,
   input  logic [1:0]    ex_MemToReg,
   input  logic [DW-1:0] ex_alu_result,
   input  logic [DW-1:0] ex_data_b,
   input  logic [DW-1:0] ex_norm_result,
   input  logic [RW-1:0] ex_rd,
   input  logic [RW-1:0] ex_rn,
   input  logic [RW-1:0] ex_rm,
   output logic          MemWrite_reg_mem,
   output logic          read_en_reg_mem,
   output logic          RegWrite_reg_mem,
   output logic [1:0]    MemToReg_reg_mem,
   output logic [DW-1:0] alu_result_reg,
   output logic [DW-1:0] data_b,
   output logic [DW-1:0] norm_result_mem,
   output logic [RW-1:0] rd_mem,
   output logic          valid_mem,
   output logic          fwd_rn_hit,
   output logic          fwd_rm_hit,
   output logic          fwd_load_hit,
   output logic [31:0]   bubble_cnt,
   output logic [31:0]   stall_cnt
);

   localparam logic [RW-1:0] XZR = RW'(31);

   logic fwd_src_ok;

   // Reset and flush both load an all-zero bubble; stall simply holds.
   always_ff @(posedge clk) begin
      if (reset || flush_in) begin
         valid_mem        <= 1'b0;
         MemWrite_reg_mem <= 1'b0;
         read_en_reg_mem  <= 1'b0;
         RegWrite_reg_mem <= 1'b0;
         MemToReg_reg_mem <= 2'b00;
         alu_result_reg   <= '0;
         data_b           <= '0;
         norm_result_mem  <= '0;
         rd_mem           <= '0;
      end else if (!stall_in) begin
         valid_mem        <= ex_valid;
         MemWrite_reg_mem <= ex_valid & ex_MemWrite;
         read_en_reg_mem  <= ex_valid & ex_read_en;
         RegWrite_reg_mem <= ex_valid & ex_RegWrite;
         MemToReg_reg_mem <= ex_MemToReg;
         alu_result_reg   <= ex_alu_result;
         data_b           <= ex_data_b;
         norm_result_mem  <= ex_norm_result;
         rd_mem           <= ex_rd;
      end
   end

   // XZR writes are still registered but never forwarded.
   assign fwd_src_ok   = valid_mem & RegWrite_reg_mem & (rd_mem != XZR);
   assign fwd_rn_hit   = fwd_src_ok & (rd_mem == ex_rn);
   assign fwd_rm_hit   = fwd_src_ok & (rd_mem == ex_rm);
   assign fwd_load_hit = (fwd_rn_hit | fwd_rm_hit) & (MemToReg_reg_mem == 2'b01);

`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        bubble_ev;
   logic        stall_ev;

   assign bubble_ev = flush_in | (~stall_in & ~ex_valid);
   assign stall_ev  = stall_in & ~flush_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (bubble_ev && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_q <= bubble_cnt_q + 32'd1;
         if (stall_ev && stall_cnt_q != 32'hFFFF_FFFF)   stall_cnt_q  <= stall_cnt_q + 32'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign stall_cnt  = stall_cnt_q;
`else
   assign bubble_cnt = 32'd0;
   assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; expectations follow EX_MEM_PERF_CNT_EN when defined.
module tb_ex_mem_reg;

   localparam int DW = 64;
   localparam int RW = 5;
`ifdef EX_MEM_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, stall_in, flush_in;
   logic          ex_valid, ex_MemWrite, ex_read_en, ex_RegWrite;
   logic [1:0]    ex_MemToReg;
   logic [DW-1:0] ex_alu_result, ex_data_b, ex_norm_result;
   logic [RW-1:0] ex_rd, ex_rn, ex_rm;
   logic          MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem;
   logic [1:0]    MemToReg_reg_mem;
   logic [DW-1:0] alu_result_reg, data_b, norm_result_mem;
   logic [RW-1:0] rd_mem;
   logic          valid_mem, fwd_rn_hit, fwd_rm_hit, fwd_load_hit;
   logic [31:0]   bubble_cnt, stall_cnt;

   int total = 0;
   int bad   = 0;
   int exp_bub = 0;
   int exp_stl = 0;

   ex_mem_reg #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
      .ex_valid(ex_valid), .ex_MemWrite(ex_MemWrite), .ex_read_en(ex_read_en),
      .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
      .ex_alu_result(ex_alu_result), .ex_data_b(ex_data_b), .ex_norm_result(ex_norm_result),
      .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
      .MemWrite_reg_mem(MemWrite_reg_mem), .read_en_reg_mem(read_en_reg_mem),
      .RegWrite_reg_mem(RegWrite_reg_mem), .MemToReg_reg_mem(MemToReg_reg_mem),
      .alu_result_reg(alu_result_reg), .data_b(data_b), .norm_result_mem(norm_result_mem),
      .rd_mem(rd_mem), .valid_mem(valid_mem),
      .fwd_rn_hit(fwd_rn_hit), .fwd_rm_hit(fwd_rm_hit), .fwd_load_hit(fwd_load_hit),
      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic mw, input logic re, input logic rw,
                         input logic [1:0] m2r, input logic [DW-1:0] alu,
                         input logic [DW-1:0] db, input logic [DW-1:0] nr,
                         input logic [RW-1:0] rd, input logic [RW-1:0] rn,
                         input logic [RW-1:0] rm);
      ex_valid = v; ex_MemWrite = mw; ex_read_en = re; ex_RegWrite = rw;
      ex_MemToReg = m2r; ex_alu_result = alu; ex_data_b = db; ex_norm_result = nr;
      ex_rd = rd; ex_rn = rn; ex_rm = rm;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_in = 1'b1; flush_in = 1'b0;
      set_ex(1, 1, 1, 1, 2'b01, 64'hDEAD, 64'hBEEF, 64'hCAFE, 5'd7, 5'd7, 5'd7);
      tick(); tick();
      total++;
      if ({valid_mem, MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem, MemToReg_reg_mem} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got %b want 000000",
            {valid_mem, MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem, MemToReg_reg_mem});
      end
      total++;
      if ({alu_result_reg, data_b, norm_result_mem} !== '0 || rd_mem !== 5'd0) begin
         bad++; $display("FAIL reset_data got alu=%h b=%h n=%h rd=%0d want all 0",
            alu_result_reg, data_b, norm_result_mem, rd_mem);
      end
      total++;
      if ({fwd_rn_hit, fwd_rm_hit, fwd_load_hit} !== 3'b0 || bubble_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         bad++; $display("FAIL reset_fwd_cnt got fwd=%b bub=%0d stl=%0d want 0",
            {fwd_rn_hit, fwd_rm_hit, fwd_load_hit}, bubble_cnt, stall_cnt);
      end
      reset = 1'b0; stall_in = 1'b0;
   endtask

   task automatic test_load();
      set_ex(1, 0, 0, 1, 2'b00, 64'h1000, 64'hAA, 64'hBB, 5'd3, 5'd3, 5'd7);
      tick();
      total++;
      if (alu_result_reg !== 64'h1000 || rd_mem !== 5'd3 || RegWrite_reg_mem !== 1'b1 ||
          valid_mem !== 1'b1 || data_b !== 64'hAA || norm_result_mem !== 64'hBB) begin
         bad++; $display("FAIL load_fields got alu=%h rd=%0d rw=%b v=%b b=%h n=%h want 1000/3/1/1/aa/bb",
            alu_result_reg, rd_mem, RegWrite_reg_mem, valid_mem, data_b, norm_result_mem);
      end
      total++;
      if ({fwd_rn_hit, fwd_rm_hit, fwd_load_hit} !== 3'b100) begin
         bad++; $display("FAIL load_fwd got %b want 100", {fwd_rn_hit, fwd_rm_hit, fwd_load_hit});
      end
      ex_rn = 5'd4; #1;
      total++;
      if (fwd_rn_hit !== 1'b0) begin
         bad++; $display("FAIL load_fwd_miss got %b want 0", fwd_rn_hit);
      end
      // back-to-back load replaces the previous contents
      set_ex(1, 1, 0, 0, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h11, 64'h22, 5'd12, 5'd12, 5'd12);
      tick();
      total++;
      if (alu_result_reg !== 64'h1234_5678_9ABC_DEF0 || MemWrite_reg_mem !== 1'b1 ||
          MemToReg_reg_mem !== 2'b10 || fwd_rn_hit !== 1'b0 || rd_mem !== 5'd12) begin
         bad++; $display("FAIL back_to_back got alu=%h mw=%b m2r=%b fwd=%b rd=%0d want 123456789abcdef0/1/10/0/12",
            alu_result_reg, MemWrite_reg_mem, MemToReg_reg_mem, fwd_rn_hit, rd_mem);
      end
   endtask

   task automatic test_load_producer();
      set_ex(1, 0, 1, 1, 2'b01, 64'h40, 64'h0, 64'h0, 5'd5, 5'd0, 5'd5);
      tick();
      total++;
      if ({fwd_rn_hit, fwd_rm_hit, fwd_load_hit} !== 3'b011 || read_en_reg_mem !== 1'b1) begin
         bad++; $display("FAIL load_producer got fwd=%b re=%b want 011/1",
            {fwd_rn_hit, fwd_rm_hit, fwd_load_hit}, read_en_reg_mem);
      end
      set_ex(1, 0, 1, 1, 2'b01, 64'h40, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31);
      tick();
      total++;
      if ({fwd_rn_hit, fwd_rm_hit, fwd_load_hit} !== 3'b000 || RegWrite_reg_mem !== 1'b1 || rd_mem !== 5'd31) begin
         bad++; $display("FAIL xzr got fwd=%b rw=%b rd=%0d want 000/1/31",
            {fwd_rn_hit, fwd_rm_hit, fwd_load_hit}, RegWrite_reg_mem, rd_mem);
      end
   endtask

   task automatic test_stall();
      set_ex(1, 1, 0, 0, 2'b10, 64'h2222, 64'h3333, 64'h4444, 5'd9, 5'd1, 5'd2);
      tick();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_ex(1, 0, 1, 1, 2'b01, 64'h9000 + i, 64'h1, 64'h2, 5'd20, 5'd20, 5'd20);
         tick();
         exp_stl++;
         total++;
         if (alu_result_reg !== 64'h2222 || data_b !== 64'h3333 || norm_result_mem !== 64'h4444 ||
             rd_mem !== 5'd9 || MemWrite_reg_mem !== 1'b1 || RegWrite_reg_mem !== 1'b0 ||
             MemToReg_reg_mem !== 2'b10 || valid_mem !== 1'b1) begin
            bad++; $display("FAIL stall_hold cyc=%0d got alu=%h rd=%0d mw=%b rw=%b m2r=%b want 2222/9/1/0/10",
               i, alu_result_reg, rd_mem, MemWrite_reg_mem, RegWrite_reg_mem, MemToReg_reg_mem);
         end
      end
      total++;
      if (stall_cnt !== (PERF ? 32'(exp_stl) : 32'd0) || bubble_cnt !== 32'd0) begin
         bad++; $display("FAIL stall_cnt got stl=%0d bub=%0d want %0d/0",
            stall_cnt, bubble_cnt, PERF ? exp_stl : 0);
      end
   endtask

   task automatic test_flush_priority();
      stall_in = 1'b1; flush_in = 1'b1;
      set_ex(1, 1, 1, 1, 2'b01, 64'h77, 64'h88, 64'h99, 5'd6, 5'd6, 5'd6);
      tick();
      exp_bub++;
      total++;
      if ({valid_mem, MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem, MemToReg_reg_mem} !== 6'b0 ||
          {alu_result_reg, data_b, norm_result_mem} !== '0 || rd_mem !== 5'd0) begin
         bad++; $display("FAIL flush_bubble got v=%b rw=%b alu=%h rd=%0d want all 0",
            valid_mem, RegWrite_reg_mem, alu_result_reg, rd_mem);
      end
      total++;
      if (bubble_cnt !== (PERF ? 32'(exp_bub) : 32'd0) || stall_cnt !== (PERF ? 32'(exp_stl) : 32'd0)) begin
         bad++; $display("FAIL flush_cnt got bub=%0d stl=%0d want %0d/%0d",
            bubble_cnt, stall_cnt, PERF ? exp_bub : 0, PERF ? exp_stl : 0);
      end
      stall_in = 1'b0; flush_in = 1'b0;
   endtask

   task automatic test_invalid_gate();
      set_ex(0, 1, 1, 1, 2'b01, 64'h55, 64'h66, 64'h77, 5'd8, 5'd8, 5'd8);
      tick();
      exp_bub++;
      total++;
      if ({MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem, valid_mem} !== 4'b0 ||
          {fwd_rn_hit, fwd_rm_hit, fwd_load_hit} !== 3'b0 || alu_result_reg !== 64'h55) begin
         bad++; $display("FAIL invalid_gate got mw=%b re=%b rw=%b v=%b fwd=%b alu=%h want 0/0/0/0/000/55",
            MemWrite_reg_mem, read_en_reg_mem, RegWrite_reg_mem, valid_mem,
            {fwd_rn_hit, fwd_rm_hit, fwd_load_hit}, alu_result_reg);
      end
      total++;
      if (bubble_cnt !== (PERF ? 32'(exp_bub) : 32'd0)) begin
         bad++; $display("FAIL invalid_cnt got %0d want %0d", bubble_cnt, PERF ? exp_bub : 0);
      end
   endtask

   task automatic test_saturation();
      set_ex(1, 0, 0, 0, 2'b00, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
`ifdef EX_MEM_PERF_CNT_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
`endif
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (stall_cnt !== (PERF ? 32'hFFFF_FFFF : 32'd0)) begin
            bad++; $display("FAIL stall_saturate cyc=%0d got %h want %h",
               i, stall_cnt, PERF ? 32'hFFFF_FFFF : 32'd0);
         end
      end
      total++;
      if (bubble_cnt !== (PERF ? 32'(exp_bub) : 32'd0)) begin
         bad++; $display("FAIL saturate_bub got %0d want %0d", bubble_cnt, PERF ? exp_bub : 0);
      end
      stall_in = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      stall_in = 1'b1; flush_in = 1'b1; reset = 1'b1;
      set_ex(1, 1, 1, 1, 2'b11, 64'h5A, 64'h5B, 64'h5C, 5'd10, 5'd10, 5'd10);
      tick();
      total++;
      if (valid_mem !== 1'b0 || bubble_cnt !== 32'd0 || stall_cnt !== 32'd0 || alu_result_reg !== '0) begin
         bad++; $display("FAIL reset_mid got v=%b bub=%0d stl=%0d alu=%h want 0",
            valid_mem, bubble_cnt, stall_cnt, alu_result_reg);
      end
      reset = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
      tick();
      total++;
      if (valid_mem !== 1'b1 || alu_result_reg !== 64'h5A || MemToReg_reg_mem !== 2'b11 || fwd_rn_hit !== 1'b1) begin
         bad++; $display("FAIL first_load got v=%b alu=%h m2r=%b fwd=%b want 1/5a/11/1",
            valid_mem, alu_result_reg, MemToReg_reg_mem, fwd_rn_hit);
      end
   endtask

   initial begin
      reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
      set_ex(0, 0, 0, 0, 2'b00, '0, '0, '0, '0, '0, '0);
      test_reset();
      test_load();
      test_load_producer();
      test_stall();
      test_flush_priority();
      test_invalid_gate();
      test_saturation();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
